stdp_potentiation_unit: RTL and testbench

Sequential STDP potentiation engine for one synapse: tracks time since the last presynaptic spike, and on each postsynaptic spike computes Δw = |a_plus|·exp(−|dt·tau_plus|) through a 4-stage registered datapath, then adds it to a stored weight with saturation at w_max. It complements the combinational depression path (pre-after-post) by handling the post-after-pre direction. It sits between the Izhikevich core's spike outputs and the synapse weight store. All arithmetic is sign-magnitude Q(N−Q).Q: bit N−1 is the sign, the rest is magnitude.

---
 rtl/stdp_potentiation_unit.sv | 206 ++++++++++++++++++++
 tb/tb_stdp_potentiation_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_potentiation_unit.sv
// ============================================================================
// Module   : stdp_potentiation_unit
// Purpose  : Post-after-pre STDP potentiation: dw = |a_plus|*exp(-|dt*tau_plus|)
//            via a 4-stage sign-magnitude datapath, saturating weight update.
//            Optional 1-deep pending buffer: define STDP_POS_PENDING_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stdp_potentiation_unit #(
   parameter int N     = 32,
   parameter int Q     = 16,
   parameter int CNT_W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pre_spike_i,
   input  logic         post_spike_i,
   input  logic [N-1:0] a_plus_i,
   input  logic [N-1:0] tau_plus_i,
   input  logic [N-1:0] m1_i,
   input  logic [N-1:0] b1_i,
   input  logic [N-1:0] m2_i,
   input  logic [N-1:0] b2_i,
   input  logic [N-1:0] w_max_i,
   input  logic         load_weight_i,
   input  logic [N-1:0] weight_in_i,
   output logic [N-1:0] weight_o,
   output logic [N-1:0] weight_change_o,
   output logic         update_valid_o,
   output logic         busy_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MULT  = 3'd1,
      S_EXP   = 3'd2,
      S_SCALE = 3'd3,
      S_APPLY = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] AGE_MAX  = '1;
   localparam logic [N-2:0]     ONE_MAG  = {{(N-2){1'b0}}, 1'b1} << Q;
   localparam logic [N-2:0]     HALF_MAG = ONE_MAG >> 1;

   function automatic logic [N-1:0] sm_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [2*N-3:0] prod;
      logic [2*N-3:0] shf;
      logic [N-2:0]   mag;
      prod = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
      shf  = prod >> Q;
      mag  = (|shf[2*N-3:N-1]) ? '1 : shf[N-2:0];
      return {a[N-1] ^ b[N-1], mag};
   endfunction

   function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] sum;
      logic [N-1:0] res;
      sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
      if (a[N-1] == b[N-1])
         res = {a[N-1], (sum[N-1] ? {(N-1){1'b1}} : sum[N-2:0])};
      else if (a[N-2:0] >= b[N-2:0])
         res = {a[N-1], a[N-2:0] - b[N-2:0]};
      else
         res = {b[N-1], b[N-2:0] - a[N-2:0]};
      return res;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] age_q, age_d;
   logic             pre_seen_q, pre_seen_d;
   logic [CNT_W-1:0] dt_q, dt_d;
   logic [N-1:0]     acc_q, acc_d;
   logic [N-1:0]     weight_q, weight_d;
   logic [N-1:0]     wchg_q, wchg_d;
   logic             valid_q, valid_d;
`ifdef STDP_POS_PENDING_EN
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] pend_dt_q, pend_dt_d;
`endif

   logic [CNT_W-1:0] w_age_inc;
   logic [CNT_W-1:0] w_dt_now;
   logic             w_accept;
   logic [N-1:0]     w_dt_fix;
   logic             w_seg1;
   logic [N-1:0]     w_yraw;
   logic [N-1:0]     w_y;
   logic [N-1:0]     w_sum;
   logic             unused_signs;

   assign w_age_inc = (age_q == AGE_MAX) ? AGE_MAX : age_q + {{(CNT_W-1){1'b0}}, 1'b1};
   // A coincident pre/post pair is a zero interval, not age+1.
   assign w_dt_now  = (pre_spike_i && post_spike_i) ? '0 : w_age_inc;
   assign w_accept  = post_spike_i && (pre_seen_q || pre_spike_i);
   assign w_dt_fix  = N'(dt_q) << Q;

   // acc_q holds |t1| in EXP; x = -|t1| selects the linear exp segment.
   assign w_seg1 = (acc_q[N-2:0] >= HALF_MAG);
   assign w_yraw = sm_add(sm_mul(w_seg1 ? m1_i : m2_i, {1'b1, acc_q[N-2:0]}),
                          w_seg1 ? b1_i : b2_i);
   assign w_y    = w_yraw[N-1] ? '0
                 : ((w_yraw[N-2:0] > ONE_MAG) ? {1'b0, ONE_MAG} : w_yraw);
   assign w_sum  = sm_add(weight_q, acc_q);

   assign unused_signs = ^{a_plus_i[N-1], tau_plus_i[N-1]};

   always_comb begin
      state_d    = state_q;
      age_d      = pre_spike_i ? '0 : w_age_inc;
      pre_seen_d = pre_seen_q | pre_spike_i;
      dt_d       = dt_q;
      acc_d      = acc_q;
      weight_d   = weight_q;
      wchg_d     = wchg_q;
      valid_d    = 1'b0;
`ifdef STDP_POS_PENDING_EN
      pend_d     = pend_q;
      pend_dt_d  = pend_dt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (load_weight_i)
               weight_d = weight_in_i;
`ifdef STDP_POS_PENDING_EN
            if (pend_q) begin
               dt_d    = pend_dt_q;
               pend_d  = 1'b0;
               state_d = S_MULT;
            end else if (w_accept) begin
               dt_d    = w_dt_now;
               state_d = S_MULT;
            end
`else
            if (w_accept) begin
               dt_d    = w_dt_now;
               state_d = S_MULT;
            end
`endif
         end
         S_MULT: begin
            acc_d   = sm_mul(w_dt_fix, {1'b0, tau_plus_i[N-2:0]});
            state_d = S_EXP;
         end
         S_EXP: begin
            acc_d   = w_y;
            state_d = S_SCALE;
         end
         S_SCALE: begin
            acc_d   = sm_mul({1'b0, a_plus_i[N-2:0]}, acc_q);
            state_d = S_APPLY;
         end
         S_APPLY: begin
            weight_d = (!w_sum[N-1] && (w_sum > w_max_i)) ? w_max_i : w_sum;
            wchg_d   = acc_q;
            valid_d  = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef STDP_POS_PENDING_EN
      if ((state_q != S_IDLE) && post_spike_i && !pend_q) begin
         pend_d    = 1'b1;
         pend_dt_d = w_dt_now;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         age_q      <= '0;
         pre_seen_q <= 1'b0;
         dt_q       <= '0;
         acc_q      <= '0;
         weight_q   <= '0;
         wchg_q     <= '0;
         valid_q    <= 1'b0;
`ifdef STDP_POS_PENDING_EN
         pend_q     <= 1'b0;
         pend_dt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         age_q      <= age_d;
         pre_seen_q <= pre_seen_d;
         dt_q       <= dt_d;
         acc_q      <= acc_d;
         weight_q   <= weight_d;
         wchg_q     <= wchg_d;
         valid_q    <= valid_d;
`ifdef STDP_POS_PENDING_EN
         pend_q     <= pend_d;
         pend_dt_q  <= pend_dt_d;
`endif
      end
   end

   assign weight_o        = weight_q;
   assign weight_change_o = wchg_q;
   assign update_valid_o  = valid_q;
   assign busy_o          = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_stdp_potentiation_unit.sv
// ============================================================================
// Module   : tb_stdp_potentiation_unit
// Purpose  : Self-checking bench: vector table, corner sequences and a
//            randomized run against an edge-indexed reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stdp_potentiation_unit;

   localparam longint MAXM = 64'h7FFF_FFFF;
`ifdef STDP_POS_PENDING_EN
   localparam bit PEND_EN = 1'b1;
`else
   localparam bit PEND_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pre_spike, post_spike, load_weight;
   logic [31:0] a_plus, tau_plus, m1, b1, m2, b2, w_max, weight_in;
   logic [31:0] weight, weight_change;
   logic        update_valid, busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stdp_potentiation_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pre_spike_i     (pre_spike),
      .post_spike_i    (post_spike),
      .a_plus_i        (a_plus),
      .tau_plus_i      (tau_plus),
      .m1_i            (m1),
      .b1_i            (b1),
      .m2_i            (m2),
      .b2_i            (b2),
      .w_max_i         (w_max),
      .load_weight_i   (load_weight),
      .weight_in_i     (weight_in),
      .weight_o        (weight),
      .weight_change_o (weight_change),
      .update_valid_o  (update_valid),
      .busy_o          (busy)
   );

   typedef struct {
      int          gap;
      logic [31:0] tau, a, wmax, w0, exp_dw, exp_w;
   } vec_t;
   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic spec_params();
      tau_plus = 32'h4000; a_plus = 32'h8000;
      m1 = 32'h4000; b1 = 32'hA000; m2 = 32'h10000; b2 = 32'h10000;
      w_max = 32'h20000;
   endtask

   // pre at one edge, post gap edges later (same edge when gap==0)
   task automatic pre_then_post(input int gap);
      pre_spike = 1'b1; post_spike = (gap == 0); tick();
      pre_spike = 1'b0; post_spike = 1'b0;
      if (gap > 0) begin
         repeat (gap - 1) tick();
         post_spike = 1'b1; tick(); post_spike = 1'b0;
      end
   endtask

   task automatic load(input logic [31:0] v);
      load_weight = 1'b1; weight_in = v; tick(); load_weight = 1'b0;
   endtask

   // ---------------- reference model ----------------
   function automatic longint sat(input longint v);
      return (v > MAXM) ? MAXM : v;
   endfunction

   function automatic longint sval(input logic [31:0] v);
      return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
   endfunction

   function automatic longint calc_dw(input longint dt);
      longint t1, mxm, mx, y;
      logic [31:0] m, b;
      t1 = sat(dt * longint'(tau_plus[30:0]));
      if (t1 >= 32768) begin m = m1; b = b1; end
      else begin m = m2; b = b2; end
      mxm = sat((longint'(m[30:0]) * t1) >>> 16);
      mx  = m[31] ? mxm : -mxm;
      y   = mx + sval(b);
      if (y > MAXM) y = MAXM;
      if (y < -MAXM) y = -MAXM;
      if (y < 0) y = 0;
      if (y > 65536) y = 65536;
      return sat((longint'(a_plus[30:0]) * y) >>> 16);
   endfunction

   task automatic rand_params();
      tau_plus = $urandom_range(0, 32'h8000);  tau_plus[31] = 1'($urandom_range(0, 1));
      a_plus   = $urandom_range(0, 32'h30000); a_plus[31]   = 1'($urandom_range(0, 1));
      m1 = $urandom_range(0, 32'h20000); m1[31] = 1'($urandom_range(0, 1));
      b1 = $urandom_range(0, 32'h20000); b1[31] = 1'($urandom_range(0, 1));
      m2 = $urandom_range(0, 32'h20000); m2[31] = 1'($urandom_range(0, 1));
      b2 = $urandom_range(0, 32'h20000); b2[31] = 1'($urandom_range(0, 1));
      w_max = $urandom_range(0, 32'h40000);
   endtask

   task automatic run_random(input int edges, input int pre_div);
      int     last_pre, start, dt_now, m_dt, pend_dt;
      bit     seen, pend, idle, m_valid, exp_busy;
      longint m_w, m_chg, dw;
      @(negedge clk) rst_n = 1'b0;
      pre_spike = 1'b0; post_spike = 1'b0; load_weight = 1'b0;
      rand_params();
      tick(); tick();
      @(negedge clk) rst_n = 1'b1;
      last_pre = -1; start = -1; seen = 0; pend = 0; m_dt = 0; pend_dt = 0;
      m_w = 0; m_chg = 0;
      for (int n = 0; n < edges; n++) begin
         pre_spike   = ($urandom_range(0, pre_div - 1) == 0);
         post_spike  = ($urandom_range(0, 3) == 0);
         load_weight = ($urandom_range(0, 15) == 0);
         weight_in   = $urandom_range(0, 32'h40000);
         tick();
         dt_now  = pre_spike ? 0 : (((n - last_pre) > 255) ? 255 : (n - last_pre));
         idle    = (start < 0) || (n >= start + 5);
         m_valid = 0;
         if (start >= 0 && n == start + 4) begin
            dw  = calc_dw(longint'(m_dt));
            m_w = sat(m_w + dw);
            if (m_w > longint'(w_max)) m_w = longint'(w_max);
            m_chg = dw; m_valid = 1;
         end
         if (idle) begin
            if (load_weight) m_w = longint'(weight_in);
            if (pend) begin
               start = n; m_dt = pend_dt; pend = 0;
            end else if (post_spike && (seen || pre_spike)) begin
               start = n; m_dt = dt_now;
            end
         end else if (post_spike && !pend && PEND_EN) begin
            pend = 1; pend_dt = dt_now;
         end
         if (pre_spike) begin last_pre = n; seen = 1; end
         exp_busy = (start >= 0) && (n >= start) && (n <= start + 3);
         chk("rnd_weight", weight, 32'(m_w));
         chk("rnd_dw", weight_change, 32'(m_chg));
         chk("rnd_valid", {31'b0, update_valid}, {31'b0, m_valid});
         chk("rnd_busy", {31'b0, busy}, {31'b0, exp_busy});
      end
      pre_spike = 1'b0; post_spike = 1'b0; load_weight = 1'b0;
   endtask

   initial begin
      int cnt, first_at, second_at;
      vecs[0] = '{2, 32'h4000,     32'h8000,     32'h20000, 32'h10000, 32'h4000,  32'h14000};
      vecs[1] = '{0, 32'h4000,     32'h8000,     32'h20000, 32'h10000, 32'h8000,  32'h18000};
      vecs[2] = '{1, 32'h4000,     32'h8000,     32'h20000, 32'h10000, 32'h6000,  32'h16000};
      vecs[3] = '{4, 32'h4000,     32'h8000,     32'h20000, 32'h1F000, 32'h3000,  32'h20000};
      vecs[4] = '{3, 32'h4000,     32'h8000,     32'h20000, 32'h30000, 32'h3800,  32'h20000};
      vecs[5] = '{0, 32'h4000,     32'h80010000, 32'h20000, 32'h0,     32'h10000, 32'h10000};
      vecs[6] = '{2, 32'h80004000, 32'h8000,     32'h20000, 32'h0,     32'h4000,  32'h4000};

      rst_n = 1'b0; pre_spike = 1'b0; post_spike = 1'b0; load_weight = 1'b0;
      weight_in = '0; spec_params();
      tick(); tick();
      @(negedge clk) rst_n = 1'b1;

      // reset clears a loaded weight
      load(32'h10000);
      chk("load_before_reset", weight, 32'h10000);
      rst_n = 1'b0; #2;
      chk("rst_weight", weight, 32'h0);
      chk("rst_dw", weight_change, 32'h0);
      chk("rst_valid", {31'b0, update_valid}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      @(negedge clk) rst_n = 1'b1;

      // reset in the middle of a computation aborts it
      pre_then_post(2);
      chk("midmult_busy", {31'b0, busy}, 32'h1);
      rst_n = 1'b0; #2; rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin tick(); if (update_valid) cnt++; end
      chk("abort_valid_count", cnt, 0);
      chk("abort_weight", weight, 32'h0);
      chk("abort_busy", {31'b0, busy}, 32'h0);

      // post without any prior pre is ignored
      post_spike = 1'b1; tick(); post_spike = 1'b0;
      chk("nopre_busy", {31'b0, busy}, 32'h0);
      cnt = 0;
      for (int k = 0; k < 6; k++) begin tick(); if (update_valid) cnt++; end
      chk("nopre_valid_count", cnt, 0);

      // vector table
      for (int i = 0; i < 7; i++) begin
         spec_params();
         tau_plus = vecs[i].tau; a_plus = vecs[i].a; w_max = vecs[i].wmax;
         load(vecs[i].w0);
         pre_then_post(vecs[i].gap);
         chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'h1);
         repeat (3) tick();
         chk($sformatf("v%0d_early_valid", i), {31'b0, update_valid}, 32'h0);
         tick();
         chk($sformatf("v%0d_valid", i), {31'b0, update_valid}, 32'h1);
         chk($sformatf("v%0d_dw", i), weight_change, vecs[i].exp_dw);
         chk($sformatf("v%0d_weight", i), weight, vecs[i].exp_w);
         chk($sformatf("v%0d_idle", i), {31'b0, busy}, 32'h0);
         tick();
         chk($sformatf("v%0d_valid_drop", i), {31'b0, update_valid}, 32'h0);
      end

      // weight climbs 1.0 -> 1.5 -> 2.0 -> 2.0 with coincident spikes
      spec_params();
      load(32'h10000);
      for (int r = 0; r < 3; r++) begin
         pre_then_post(0);
         repeat (4) tick();
         chk("sat_seq_dw", weight_change, 32'h8000);
         chk("sat_seq_weight", weight, (r == 0) ? 32'h18000 : 32'h20000);
      end

      // long silence saturates the age counter: dt=255, y clamps to 0
      load(32'h10000);
      pre_spike = 1'b1; tick(); pre_spike = 1'b0;
      repeat (300) tick();
      post_spike = 1'b1; tick(); post_spike = 1'b0;
      repeat (4) tick();
      chk("agesat_valid", {31'b0, update_valid}, 32'h1);
      chk("agesat_dw", weight_change, 32'h0);
      chk("agesat_weight", weight, 32'h10000);

      // back-to-back posts: pre at P, posts at P+1 (E), E+1, E+2
      load(32'h10000);
      pre_spike = 1'b1; tick(); pre_spike = 1'b0;
      post_spike = 1'b1; tick(); tick(); tick(); post_spike = 1'b0;
      cnt = 0; first_at = -1; second_at = -1;
      for (int k = 3; k <= 16; k++) begin
         tick();
         if (update_valid) begin
            cnt++;
            if (first_at < 0) first_at = k; else second_at = k;
         end
      end
      chk("dbl_first_at", first_at, 4);
`ifdef STDP_POS_PENDING_EN
      chk("dbl_count", cnt, 2);
      chk("dbl_second_at", second_at, 9);
      chk("dbl_last_dw", weight_change, 32'h4000);
      chk("dbl_weight", weight, 32'h1A000);
`else
      chk("dbl_count", cnt, 1);
      chk("dbl_second_at", second_at, -1);
      chk("dbl_last_dw", weight_change, 32'h6000);
      chk("dbl_weight", weight, 32'h16000);
`endif

      // load while busy is ignored
      load(32'h10000);
      pre_then_post(2);
      load_weight = 1'b1; weight_in = 32'h50000; tick(); load_weight = 1'b0;
      repeat (3) tick();
      chk("busyload_weight", weight, 32'h14000);
      tick();

      // load together with an accepted post: APPLY builds on the loaded value
      load(32'h10000);
      pre_spike = 1'b1; tick(); pre_spike = 1'b0; tick();
      post_spike = 1'b1; load_weight = 1'b1; weight_in = 32'h4000; tick();
      post_spike = 1'b0; load_weight = 1'b0;
      repeat (4) tick();
      chk("acceptload_weight", weight, 32'h8000);
      tick();

      run_random(600, 10);
      run_random(600, 6);
      run_random(900, 300);
      run_random(600, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
